mining_job_scheduler: RTL and testbench

- Sequences one sha_hasher instance through mining jobs.
- Accepts a job (midstate, header fields, nonce range) over a valid/ready handshake and loads the hasher's start time/nonce by pulsing the hasher reset.
- Gates hs_write_en for exactly the requested nonce count plus pipeline latency.
- Captures the first solution, or reports range exhaustion, on a held result handshake.

---
 rtl/mining_job_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_mining_job_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mining_job_scheduler.sv
// Mining job scheduler: accepts one job at a time, loads a single sha_hasher
// through its reset strobe, and gates hs_write_en for the requested nonce
// count plus the hasher pipeline latency. It then reports the first solution,
// or that the range was exhausted, on a result handshake that holds until consumed.
module mining_job_scheduler #(
    parameter int PIPE_LATENCY = 131,
    parameter int LOAD_CYCLES  = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [255:0] job_digest_initial,
    input  logic [255:0] job_midstate,
    input  logic [31:0]  job_merkle,
    input  logic [31:0]  job_time,
    input  logic [31:0]  job_target,
    input  logic [31:0]  job_nonce,
    input  logic [31:0]  job_count,
    input  logic         abort,
    output logic         hs_rst_n,
    output logic         hs_write_en,
    output logic [255:0] hs_digest_initial,
    output logic [255:0] hs_digest_in,
    output logic [31:0]  hs_merkle,
    output logic [31:0]  hs_time,
    output logic [31:0]  hs_target,
    output logic [31:0]  hs_nonce,
    input  logic         hs_valid,
    input  logic [31:0]  hs_time_out,
    input  logic [31:0]  hs_nonce_out,
    input  logic [255:0] hs_result,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_found,
    output logic [31:0]  res_time,
    output logic [31:0]  res_nonce,
    output logic [255:0] res_hash,
    output logic         busy,
    output logic [31:0]  hash_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_REPORT
    } state_t;

    // Last value of the load counter; the hasher is released on that cycle.
    localparam logic [15:0] LOAD_LAST = 16'(LOAD_CYCLES - 1);

    state_t         state_q;
    logic           job_ready_q;
    logic           hs_rst_n_q;
    logic           hs_write_en_q;
    logic [255:0]   hs_digest_initial_q;
    logic [255:0]   hs_digest_in_q;
    logic [31:0]    hs_merkle_q;
    logic [31:0]    hs_time_q;
    logic [31:0]    hs_target_q;
    logic [31:0]    hs_nonce_q;
    logic           res_valid_q;
    logic           res_found_q;
    logic [31:0]    res_time_q;
    logic [31:0]    res_nonce_q;
    logic [255:0]   res_hash_q;
    logic [31:0]    hash_count_q;
    // 33 bits so that job_count = 0xFFFFFFFF plus the latency cannot wrap.
    logic [32:0]    run_cnt_q;
    logic [15:0]    load_cnt_q;

    // Job sequencing FSM; every hasher strobe and result field is registered here.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q             <= S_IDLE;
            job_ready_q         <= 1'b0;
            hs_rst_n_q          <= 1'b0;
            hs_write_en_q       <= 1'b0;
            hs_digest_initial_q <= '0;
            hs_digest_in_q      <= '0;
            hs_merkle_q         <= '0;
            hs_time_q           <= '0;
            hs_target_q         <= '0;
            hs_nonce_q          <= '0;
            res_valid_q         <= 1'b0;
            res_found_q         <= 1'b0;
            res_time_q          <= '0;
            res_nonce_q         <= '0;
            res_hash_q          <= '0;
            hash_count_q        <= '0;
            run_cnt_q           <= '0;
            load_cnt_q          <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    hs_rst_n_q    <= 1'b1;
                    hs_write_en_q <= 1'b0;
                    if (job_valid && job_ready_q) begin
                        job_ready_q         <= 1'b0;
                        hs_digest_initial_q <= job_digest_initial;
                        hs_digest_in_q      <= job_midstate;
                        hs_merkle_q         <= job_merkle;
                        hs_time_q           <= job_time;
                        hs_target_q         <= job_target;
                        hs_nonce_q          <= job_nonce;
                        hash_count_q        <= '0;
                        run_cnt_q           <= {1'b0, job_count} + 33'(PIPE_LATENCY);
                        load_cnt_q          <= '0;
                        if (job_count == 32'd0) begin
                            // Empty range: report straight away, hasher untouched.
                            state_q     <= S_REPORT;
                            res_valid_q <= 1'b1;
                            res_found_q <= 1'b0;
                            res_time_q  <= '0;
                            res_nonce_q <= '0;
                            res_hash_q  <= '0;
                        end else begin
                            state_q    <= S_LOAD;
                            hs_rst_n_q <= 1'b0;
                        end
                    end else begin
                        job_ready_q <= 1'b1;
                    end
                end

                S_LOAD: begin
                    if (abort) begin
                        state_q       <= S_IDLE;
                        hs_rst_n_q    <= 1'b1;
                        hs_write_en_q <= 1'b0;
                        job_ready_q   <= 1'b1;
                    end else if (load_cnt_q == LOAD_LAST) begin
                        // Release the hasher and enable it on the same edge.
                        state_q       <= S_RUN;
                        hs_rst_n_q    <= 1'b1;
                        hs_write_en_q <= 1'b1;
                    end else begin
                        load_cnt_q <= load_cnt_q + 16'd1;
                    end
                end

                S_RUN: begin
                    if (hs_write_en_q) begin
                        hash_count_q <= hash_count_q + 32'd1;
                        run_cnt_q    <= run_cnt_q - 33'd1;
                    end
                    if (abort) begin
                        state_q       <= S_IDLE;
                        hs_write_en_q <= 1'b0;
                        hs_rst_n_q    <= 1'b1;
                        job_ready_q   <= 1'b1;
                    end else if (hs_write_en_q && hs_valid) begin
                        // A solution wins even on the last enabled cycle.
                        state_q       <= S_REPORT;
                        hs_write_en_q <= 1'b0;
                        res_valid_q   <= 1'b1;
                        res_found_q   <= 1'b1;
                        res_time_q    <= hs_time_out;
                        res_nonce_q   <= hs_nonce_out;
                        res_hash_q    <= hs_result;
                    end else if (hs_write_en_q && run_cnt_q == 33'd1) begin
                        state_q       <= S_REPORT;
                        hs_write_en_q <= 1'b0;
                        res_valid_q   <= 1'b1;
                        res_found_q   <= 1'b0;
                        res_time_q    <= '0;
                        res_nonce_q   <= '0;
                        res_hash_q    <= '0;
                    end
                end

                S_REPORT: begin
                    hs_write_en_q <= 1'b0;
                    if (res_ready) begin
                        state_q     <= S_IDLE;
                        res_valid_q <= 1'b0;
                        job_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign job_ready         = job_ready_q;
    assign hs_rst_n          = hs_rst_n_q;
    assign hs_write_en       = hs_write_en_q;
    assign hs_digest_initial = hs_digest_initial_q;
    assign hs_digest_in      = hs_digest_in_q;
    assign hs_merkle         = hs_merkle_q;
    assign hs_time           = hs_time_q;
    assign hs_target         = hs_target_q;
    assign hs_nonce          = hs_nonce_q;
    assign res_valid         = res_valid_q;
    assign res_found         = res_found_q;
    assign res_time          = res_time_q;
    assign res_nonce         = res_nonce_q;
    assign res_hash          = res_hash_q;
    assign hash_count        = hash_count_q;
    assign busy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_mining_job_scheduler.sv
// Testbench for mining_job_scheduler: directed jobs against a behavioural
// hasher stand-in, with a scoreboard queue of expected results that is
// drained by an independent result monitor.
module tb_mining_job_scheduler;

    localparam logic [255:0] SOL_HASH = 256'h00000000000000000003a1b2c3d4e5f60718293a4b5c6d7e8f90a1b2c3d4e5f6;
    localparam logic [31:0]  SOL_NONCE = 32'h00001234;
    localparam logic [31:0]  SOL_TIME  = 32'h5F000000;

    typedef struct {
        logic         found;
        logic [31:0]  t;
        logic [31:0]  n;
        logic [255:0] h;
        logic [31:0]  hc;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic [255:0] job_digest_initial = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    logic [255:0] job_midstate = 256'h0123456789abcdef0123456789abcdef0123456789abcdef0123456789abcdef;
    logic [31:0]  job_merkle = 32'hCAFEF00D;
    logic [31:0]  job_time = 32'h5F000000;
    logic [31:0]  job_target = 32'h1d00ffff;
    logic [31:0]  job_nonce = 32'd0;
    logic [31:0]  job_count = 32'd0;
    logic         abort = 1'b0;
    logic         hs_rst_n;
    logic         hs_write_en;
    logic [255:0] hs_digest_initial;
    logic [255:0] hs_digest_in;
    logic [31:0]  hs_merkle;
    logic [31:0]  hs_time;
    logic [31:0]  hs_target;
    logic [31:0]  hs_nonce;
    logic         hs_valid = 1'b0;
    logic [31:0]  hs_time_out = SOL_TIME;
    logic [31:0]  hs_nonce_out = SOL_NONCE;
    logic [255:0] hs_result = SOL_HASH;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic         res_found;
    logic [31:0]  res_time;
    logic [31:0]  res_nonce;
    logic [255:0] res_hash;
    logic         busy;
    logic [31:0]  hash_count;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    exp_t sb_q[$];
    exp_t e;
    logic prev_rv = 1'b0;

    // Hasher stand-in and activity counters
    int   found_at = 0;
    int   en_run = 0;
    int   en_total = 0;
    int   we_rises = 0;
    int   rst_low = 0;
    logic prev_we = 1'b0;

    mining_job_scheduler #(.PIPE_LATENCY(131), .LOAD_CYCLES(2)) dut (
        .CLK(CLK), .RST(RST),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_digest_initial(job_digest_initial), .job_midstate(job_midstate),
        .job_merkle(job_merkle), .job_time(job_time), .job_target(job_target),
        .job_nonce(job_nonce), .job_count(job_count), .abort(abort),
        .hs_rst_n(hs_rst_n), .hs_write_en(hs_write_en),
        .hs_digest_initial(hs_digest_initial), .hs_digest_in(hs_digest_in),
        .hs_merkle(hs_merkle), .hs_time(hs_time), .hs_target(hs_target), .hs_nonce(hs_nonce),
        .hs_valid(hs_valid), .hs_time_out(hs_time_out), .hs_nonce_out(hs_nonce_out),
        .hs_result(hs_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_found(res_found),
        .res_time(res_time), .res_nonce(res_nonce), .res_hash(res_hash),
        .busy(busy), .hash_count(hash_count)
    );

    always #5 CLK = ~CLK;

    function automatic void chk(string nm, logic [255:0] act, logic [255:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    endfunction

    function automatic void push_exp(logic f, logic [31:0] t, logic [31:0] n, logic [255:0] h, logic [31:0] hc);
        exp_t x;
        x.found = f; x.t = t; x.n = n; x.h = h; x.hc = hc;
        sb_q.push_back(x);
    endfunction

    // Hasher model: flags a solution during the found_at-th enabled cycle after a load
    always @(negedge CLK) begin
        if (RST && !hs_rst_n) begin
            rst_low++;
            en_run = 0;
        end
        hs_valid = RST && hs_write_en && (found_at != 0) && (en_run + 1 == found_at);
        if (RST && hs_write_en) begin
            en_run++;
            en_total++;
            if (!prev_we) we_rises++;
        end
        prev_we = hs_write_en;
    end

    // Result monitor: compares each newly presented result with the scoreboard head
    always @(negedge CLK) begin
        if (!RST) begin
            prev_rv = 1'b0;
        end else begin
            if (res_valid && !prev_rv) begin
                if (sb_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_result: got res_valid=1 nonce=0x%0h, required no result", res_nonce);
                end else begin
                    e = sb_q.pop_front();
                    chk("res_found", res_found, e.found);
                    chk("res_time", res_time, e.t);
                    chk("res_nonce", res_nonce, e.n);
                    chk("res_hash", res_hash, e.h);
                    chk("hash_count", hash_count, e.hc);
                end
            end
            prev_rv = res_valid;
        end
    end

    task automatic send_job(input logic [31:0] nonce, input logic [31:0] cnt, input int fat);
        int b;
        @(negedge CLK);
        job_nonce = nonce;
        job_count = cnt;
        found_at  = fat;
        job_valid = 1'b1;
        b = 0;
        while (!job_ready && b < 100) begin
            @(negedge CLK);
            b++;
        end
        if (!job_ready) begin
            total_cnt++;
            $display("FAIL job_accept: got job_ready=0 for 100 cycles, required 1");
            job_valid = 1'b0;
        end else begin
            @(posedge CLK);
            rst_low  = 0;
            en_total = 0;
            we_rises = 0;
            @(negedge CLK);
            job_valid = 1'b0;
        end
    endtask

    task automatic wait_result(output int cycles);
        int b;
        b = 0;
        while (!res_valid && b < 3000) begin
            @(negedge CLK);
            b++;
        end
        cycles = b;
        if (!res_valid) begin
            total_cnt++;
            $display("FAIL result_timeout: got res_valid=0 after %0d cycles, required 1", b);
        end
        #1;
    endtask

    task automatic release_result();
        @(negedge CLK);
        res_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        res_ready = 1'b0;
        chk("idle_busy", busy, 1'b0);
        chk("idle_job_ready", job_ready, 1'b1);
        chk("idle_res_valid", res_valid, 1'b0);
    endtask

    task automatic wait_write_en();
        int b;
        b = 0;
        while (!hs_write_en && b < 50) begin
            @(negedge CLK);
            b++;
        end
        if (!hs_write_en) begin
            total_cnt++;
            $display("FAIL run_start: got hs_write_en=0 after %0d cycles, required 1", b);
        end
    endtask

    initial begin
        int cyc;
        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_hs_rst_n", hs_rst_n, 1'b0);
        chk("rst_write_en", hs_write_en, 1'b0);
        chk("rst_job_ready", job_ready, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_hash_count", hash_count, 32'd0);
        RST = 1'b1;
        @(negedge CLK);
        chk("post_rst_job_ready", job_ready, 1'b1);
        chk("post_rst_hs_rst_n", hs_rst_n, 1'b1);

        // Unreachable target, four nonces: 4 + 131 enabled cycles
        push_exp(1'b0, 32'd0, 32'd0, 256'd0, 32'd135);
        send_job(32'h100, 32'd4, 0);
        chk("latched_nonce", hs_nonce, 32'h100);
        chk("latched_merkle", hs_merkle, 32'hCAFEF00D);
        chk("load_busy", busy, 1'b1);
        wait_result(cyc);
        chk("a_rst_low_cycles", rst_low, 2);
        chk("a_enable_cycles", en_total, 135);
        chk("a_enable_contiguous", we_rises, 1);
        release_result();

        // Solution on the 140th enabled cycle, then a held result
        push_exp(1'b1, SOL_TIME, SOL_NONCE, SOL_HASH, 32'd140);
        send_job(32'h0, 32'd1000, 140);
        wait_result(cyc);
        chk("b_write_en_dropped", hs_write_en, 1'b0);
        chk("b_enable_cycles", en_total, 140);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("hold_res_valid", res_valid, 1'b1);
            chk("hold_res_found", res_found, 1'b1);
            chk("hold_res_nonce", res_nonce, SOL_NONCE);
            chk("hold_res_time", res_time, SOL_TIME);
            chk("hold_res_hash", res_hash, SOL_HASH);
            chk("hold_job_ready", job_ready, 1'b0);
            chk("hold_write_en", hs_write_en, 1'b0);
        end
        release_result();

        // Empty range: report one cycle after accept, hasher untouched
        push_exp(1'b0, 32'd0, 32'd0, 256'd0, 32'd0);
        send_job(32'h300, 32'd0, 0);
        wait_result(cyc);
        chk("c_report_latency", cyc, 0);
        chk("c_rst_low_cycles", rst_low, 0);
        chk("c_enable_cycles", en_total, 0);
        release_result();

        // Abort on RUN cycle 50
        send_job(32'h400, 32'd1000, 0);
        wait_write_en();
        repeat (49) @(negedge CLK);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        chk("abort_write_en", hs_write_en, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_job_ready", job_ready, 1'b1);
        chk("abort_hs_rst_n", hs_rst_n, 1'b1);
        repeat (200) @(negedge CLK);
        #1;
        chk("abort_no_result", res_valid, 1'b0);
        chk("abort_enable_cycles", en_total, 50);

        // Asynchronous reset on RUN cycle 20
        send_job(32'h500, 32'd1000, 0);
        wait_write_en();
        repeat (19) @(negedge CLK);
        #2;
        RST = 1'b0;
        #1;
        chk("arst_write_en", hs_write_en, 1'b0);
        chk("arst_hs_rst_n", hs_rst_n, 1'b0);
        chk("arst_job_ready", job_ready, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_res_valid", res_valid, 1'b0);
        chk("arst_hash_count", hash_count, 32'd0);
        chk("arst_hs_nonce", hs_nonce, 32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (200) @(negedge CLK);
        #1;
        chk("arst_no_result", res_valid, 1'b0);

        // Next job after reset runs normally
        push_exp(1'b0, 32'd0, 32'd0, 256'd0, 32'd135);
        send_job(32'h200, 32'd4, 0);
        chk("f_latched_nonce", hs_nonce, 32'h200);
        wait_result(cyc);
        chk("f_rst_low_cycles", rst_low, 2);
        chk("f_enable_cycles", en_total, 135);
        release_result();

        repeat (5) @(negedge CLK);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion by 2000000, required finish");
        $fatal(1, "timeout");
    end

endmodule
